display_timing_gen: RTL
=======================

Name: display_timing_gen

Overview:
- Downstream consumer of the DataPath frame store; generates raster timing (hsync, vsync, de) from the programmed blanking and active sizes.
- Issues sequential frame-read addresses and forwards 8-bit frame pixels to the display pins, aligned with de.
- Frame geometry is latched once per frame, so register writes mid-frame cannot tear the raster.

Parameters:
- CNT_W, 10, width of the timing-size inputs and internal h/v counters.
- ADDR_W, 16, width of the frame read index.
- PIX_W, 8, pixel width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state.
- enable  in  1  display chip-select; start/continue raster.
- HBOut_PD  in  CNT_W  horizontal blank cycles per line.
- VBOut_PD  in  CNT_W  vertical blank lines per frame.
- AIPOut_PD  in  CNT_W  active pixels per line.
- AILOut_PD  in  CNT_W  active lines per frame.
- FrameDataIn  in  PIX_W  frame-store read data, valid 1 cycle after frame_rd.
- frame_rd  out  1  frame-store read strobe.
- FrameRInd  out  ADDR_W  frame-store read index.
- hsync  out  1  high during horizontal blank cycles.
- vsync  out  1  high during vertical blank lines.
- de  out  1  data enable; PixelOut valid.
- PixelOut  out  PIX_W  pixel to display.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.
- cfg_err  out  1  sticky error: illegal geometry latched.

Behaviour:
- Reset (reset=0, async): state=IDLE. All counters 0. Outputs frame_rd, FrameRInd, hsync, vsync, de, PixelOut, frame_done, cfg_err all 0.
- State machine: IDLE, VBLANK, HBLANK, ACTIVE.
- Line length L = HB+AIP. Frame length = (VB+AIL)*L cycles.
- IDLE: on a clock edge with enable=1, latch HB/VB/AIP/AIL.
  - Latched AIP=0, AIL=0, or AIP*AIL > 2^ADDR_W: set cfg_err=1 and stay IDLE. cfg_err clears only on reset.
  - Otherwise clear h_cnt, v_cnt and FrameRInd. Go to VBLANK if VB>0, else HBLANK if HB>0, else ACTIVE.
- h_cnt counts 0..L-1 in every line. Positions h<HB are the horizontal blank; positions h>=HB are the active region.
- v_cnt counts 0..VB+AIL-1. Lines v<VB are vertical blank lines.
- VBLANK: no reads for the whole line. Lines with v<VB are VBLANK in full, including their h<HB portion.
- HBLANK: active line, h<HB; no reads.
- ACTIVE: v>=VB and h>=HB. frame_rd=1 with the current FrameRInd; FrameRInd increments by 1 after each read.
- Line and frame wrap:
  - At h=L-1, h_cnt wraps to 0 and v_cnt increments.
  - At h=L-1 and v=VB+AIL-1, frame_done pulses for 1 cycle.
  - If enable=1 at that point, geometry is re-latched and the next frame starts on the following cycle with no gap; FrameRInd returns to 0. Otherwise go to IDLE.
- enable deassert mid-frame: the current frame completes; enable is sampled only at IDLE and at frame end.
- Output alignment: all display outputs carry 1-cycle latency relative to the internal position.
  - hsync, vsync, de are registered internal qualifiers.
  - PixelOut = FrameDataIn when de=1, else 0.
  - frame_rd and FrameRInd are not delayed.
- Counter width: HB+AIP and VB+AIL are evaluated at CNT_W+1 bits, so 1023+1023 is legal.
- Input change mid-frame: ignored until the next latch.

Test Plan:
- Reset mid-ACTIVE (reset=0 at any cycle) -> outputs 0 in the same cycle, without waiting for a clock edge. After release with enable=1, restart from VBLANK with FrameRInd=0.
- HB=2, AIP=4, VB=1, AIL=2, enable held -> frame is 18 cycles and frame_done repeats every 18 cycles.
  - frame_rd high on cycles 8-11 and 14-17 relative to frame start, FrameRInd 0..7.
  - de high on cycles 9-12 and 15-18; hsync high 2 cycles per line.
- VB=10, HB=10, AIP=100, AIL=100 -> frame = 12100 cycles.
  - First de is 1111 cycles after frame start.
  - Exactly 10000 de cycles per frame; last FrameRInd=9999.
  - PixelOut equals the frame-store contents in address order.
- enable dropped during line 5 -> frame runs to completion, frame_done pulses once, then IDLE with all outputs 0.
- AIP=0 or AIP=AIL=300 (product 90000 > 65536) with enable=1 -> cfg_err=1, no frame_rd, stays IDLE until reset.
- VB=0, HB=0, AIP=4, AIL=2 -> de continuously high for 8 cycles per frame, back-to-back frames, hsync and vsync never high.

Source files
------------

// File: rtl/display_timing_gen.sv
// Raster timing generator: hsync/vsync/de plus sequential frame-store reads.
// Geometry is captured at frame boundaries so mid-frame writes cannot tear.
module display_timing_gen #(
   parameter int CNT_W  = 10,
   parameter int ADDR_W = 16,
   parameter int PIX_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [CNT_W-1:0]  HBOut_PD,
   input  logic [CNT_W-1:0]  VBOut_PD,
   input  logic [CNT_W-1:0]  AIPOut_PD,
   input  logic [CNT_W-1:0]  AILOut_PD,
   input  logic [PIX_W-1:0]  FrameDataIn,
   output logic              frame_rd,
   output logic [ADDR_W-1:0] FrameRInd,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [PIX_W-1:0]  PixelOut,
   output logic              frame_done,
   output logic              cfg_err
);

   localparam int LW = CNT_W + 1;
   localparam int MW = (2 * CNT_W > ADDR_W) ? 2 * CNT_W + 1 : ADDR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_VBLANK,
      S_HBLANK,
      S_ACTIVE
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_hb;
   logic [CNT_W-1:0]    r_vb;
   logic [CNT_W-1:0]    r_aip;
   logic [CNT_W-1:0]    r_ail;
   logic [LW-1:0]       r_h;
   logic [LW-1:0]       r_v;
   logic [ADDR_W-1:0]   r_rd_ind;
   logic                r_hsync;
   logic                r_vsync;
   logic                r_de;
   logic                r_cfg_err;

   logic [LW-1:0]       w_h_max;
   logic [LW-1:0]       w_v_max;
   logic [LW-1:0]       w_h_nxt;
   logic [LW-1:0]       w_v_nxt;
   logic                w_run;
   logic                w_h_last;
   logic                w_v_last;
   logic                w_frame_end;
   logic [MW-1:0]       w_prod;
   logic                w_cfg_bad;
   state_t              w_start_state;
   state_t              w_run_state;

   assign w_h_max     = LW'(r_hb) + LW'(r_aip) - LW'(1);
   assign w_v_max     = LW'(r_vb) + LW'(r_ail) - LW'(1);
   assign w_run       = (r_state != S_IDLE);
   assign w_h_last    = (r_h == w_h_max);
   assign w_v_last    = (r_v == w_v_max);
   assign w_frame_end = w_run & w_h_last & w_v_last;
   assign w_h_nxt     = w_h_last ? '0 : r_h + LW'(1);
   assign w_v_nxt     = w_h_last ? r_v + LW'(1) : r_v;

   // Legality is judged on the live inputs, which are what gets latched.
   assign w_prod    = MW'(AIPOut_PD) * MW'(AILOut_PD);
   assign w_cfg_bad = (AIPOut_PD == '0) | (AILOut_PD == '0) |
                      (w_prod > (MW'(1) << ADDR_W));

   always_comb begin
      w_start_state = S_ACTIVE;
      if (VBOut_PD != '0)
         w_start_state = S_VBLANK;
      else if (HBOut_PD != '0)
         w_start_state = S_HBLANK;
   end

   always_comb begin
      w_run_state = S_ACTIVE;
      if (w_v_nxt < LW'(r_vb))
         w_run_state = S_VBLANK;
      else if (w_h_nxt < LW'(r_hb))
         w_run_state = S_HBLANK;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_hb      <= '0;
         r_vb      <= '0;
         r_aip     <= '0;
         r_ail     <= '0;
         r_h       <= '0;
         r_v       <= '0;
         r_rd_ind  <= '0;
         r_hsync   <= 1'b0;
         r_vsync   <= 1'b0;
         r_de      <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_hsync <= w_run & (r_h < LW'(r_hb));
         r_vsync <= w_run & (r_v < LW'(r_vb));
         r_de    <= (r_state == S_ACTIVE);
         if (r_state == S_ACTIVE)
            r_rd_ind <= r_rd_ind + ADDR_W'(1);

         unique case (r_state)
            S_IDLE: begin
               if (enable && !r_cfg_err) begin
                  r_hb  <= HBOut_PD;
                  r_vb  <= VBOut_PD;
                  r_aip <= AIPOut_PD;
                  r_ail <= AILOut_PD;
                  if (w_cfg_bad) begin
                     r_cfg_err <= 1'b1;
                  end else begin
                     r_h      <= '0;
                     r_v      <= '0;
                     r_rd_ind <= '0;
                     r_state  <= w_start_state;
                  end
               end
            end
            default: begin
               if (w_frame_end) begin
                  r_h      <= '0;
                  r_v      <= '0;
                  r_rd_ind <= '0;
                  r_state  <= S_IDLE;
                  if (enable) begin
                     r_hb  <= HBOut_PD;
                     r_vb  <= VBOut_PD;
                     r_aip <= AIPOut_PD;
                     r_ail <= AILOut_PD;
                     if (w_cfg_bad)
                        r_cfg_err <= 1'b1;
                     else
                        r_state <= w_start_state;
                  end
               end else begin
                  r_h     <= w_h_nxt;
                  r_v     <= w_v_nxt;
                  r_state <= w_run_state;
               end
            end
         endcase
      end
   end

   assign frame_rd   = (r_state == S_ACTIVE);
   assign FrameRInd  = r_rd_ind;
   assign frame_done = w_frame_end;
   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign de         = r_de;
   assign PixelOut   = r_de ? FrameDataIn : '0;
   assign cfg_err    = r_cfg_err;

endmodule
